// File: rtl/decode.sv
// DLX decode stage: field extraction, immediate generation, scoreboard-based
// RAW hazard detection and a one-entry held instruction feeding execute.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   if_valid/if_ready       fetch handshake (if_ready is combinational)
//   if_instr, if_pc         instruction word and its PC
//   Rs1, Rs2                register-file read addresses (combinational)
//   S1, S2                  register-file read data, one edge after Rs1/Rs2
//   ex_valid/ex_ready       execute handshake
//   ex_op..ex_b             held decoded instruction; ex_a/ex_b pass S1/S2
//   wb_valid, wb_rd         writeback retiring a write to wb_rd
//   flush                   discard the held instruction
module decode (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic [4:0]  Rs1,
  output logic [4:0]  Rs2,
  input  logic [31:0] S1,
  input  logic [31:0] S2,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [5:0]  ex_op,
  output logic [10:0] ex_func,
  output logic [4:0]  ex_rd,
  output logic        ex_wb,
  output logic [31:0] ex_imm,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        flush
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned OPW  = 6;
  localparam int unsigned FW   = 11;

  localparam logic [OPW-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPW-1:0] OP_J     = 6'h02;
  localparam logic [OPW-1:0] OP_JAL   = 6'h03;
  localparam logic [OPW-1:0] OP_BEQZ  = 6'h04;
  localparam logic [OPW-1:0] OP_BNEZ  = 6'h05;
  localparam logic [OPW-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OPW-1:0] OP_ORI   = 6'h0D;
  localparam logic [OPW-1:0] OP_XORI  = 6'h0E;
  localparam logic [OPW-1:0] OP_LHI   = 6'h0F;
  localparam logic [OPW-1:0] OP_JR    = 6'h12;
  localparam logic [OPW-1:0] OP_JALR  = 6'h13;
  localparam logic [OPW-1:0] OP_SB    = 6'h28;
  localparam logic [OPW-1:0] OP_SH    = 6'h29;
  localparam logic [OPW-1:0] OP_S2A   = 6'h2A;
  localparam logic [OPW-1:0] OP_SW    = 6'h2B;
  localparam logic [RW-1:0]  LINK_REG = 5'd31;

  // Held instruction and scoreboard
  logic            r_valid;
  logic [OPW-1:0]  r_op;
  logic [FW-1:0]   r_func;
  logic [RW-1:0]   r_rd;
  logic            r_wb;
  logic            r_owner;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_pc;
  logic [RW-1:0]   r_rs1;
  logic [RW-1:0]   r_rs2;
  logic [XLEN-1:0] r_pending;

  // Decode of the incoming instruction
  logic [OPW-1:0]  w_op;
  logic [RW-1:0]   w_src1;
  logic [RW-1:0]   w_src2;
  logic            w_use1;
  logic            w_use2;
  logic            w_has_dst;
  logic [RW-1:0]   w_dst;
  logic [RW-1:0]   w_rd;
  logic            w_wb;
  logic [FW-1:0]   w_func;
  logic [XLEN-1:0] w_imm;

  logic            w_hazard;
  logic            w_xfer;
  logic            w_dst_busy;
  logic [XLEN-1:0] w_pending_nxt;

  assign w_op   = if_instr[31:26];
  assign w_src1 = if_instr[25:21];
  assign w_src2 = if_instr[20:16];

  // Field extraction and immediate generation per opcode class
  always_comb begin
    w_use1    = 1'b1;
    w_use2    = 1'b0;
    w_has_dst = 1'b1;
    w_dst     = if_instr[20:16];
    w_func    = '0;
    w_imm     = {{16{if_instr[15]}}, if_instr[15:0]};
    case (w_op)
      OP_RTYPE: begin
        w_use2 = 1'b1;
        w_dst  = if_instr[15:11];
        w_func = if_instr[10:0];
        w_imm  = '0;
      end
      OP_J: begin
        w_use1    = 1'b0;
        w_has_dst = 1'b0;
        w_imm     = {{6{if_instr[25]}}, if_instr[25:0]};
      end
      OP_JAL: begin
        w_use1 = 1'b0;
        w_dst  = LINK_REG;
        w_imm  = {{6{if_instr[25]}}, if_instr[25:0]};
      end
      OP_BEQZ, OP_BNEZ, OP_JR: w_has_dst = 1'b0;
      OP_JALR:                 w_dst     = LINK_REG;
      OP_SB, OP_SH, OP_S2A, OP_SW: begin
        w_use2    = 1'b1;
        w_has_dst = 1'b0;
      end
      OP_ANDI, OP_ORI, OP_XORI: w_imm = {16'h0000, if_instr[15:0]};
      OP_LHI:                   w_imm = {if_instr[15:0], 16'h0000};
      default: ;
    endcase
  end

  assign w_wb = w_has_dst && (w_dst != '0);
  assign w_rd = w_has_dst ? w_dst : '0;

  // A writeback in the same cycle does not bypass the scoreboard
  assign w_hazard = if_valid && ((w_use1 && r_pending[w_src1]) ||
                                 (w_use2 && r_pending[w_src2]));
  assign if_ready = !w_hazard && !flush && (!r_valid || ex_ready);
  assign w_xfer   = if_valid && if_ready;

  // Read addresses follow the held instruction during stalls so S1/S2 stay aligned
  assign Rs1 = w_xfer ? w_src1 : r_rs1;
  assign Rs2 = w_xfer ? w_src2 : r_rs2;

  // Destination already owned by an older writer that is not retiring now
  assign w_dst_busy = r_pending[w_rd] && !(wb_valid && (wb_rd == w_rd));

  // Scoreboard update: writeback clear, flush release, then accept set (set wins)
  always_comb begin
    w_pending_nxt = r_pending;
    if (wb_valid) w_pending_nxt[wb_rd] = 1'b0;
    if (flush && r_valid && !ex_ready && r_owner) w_pending_nxt[r_rd] = 1'b0;
    if (w_xfer && w_wb) w_pending_nxt[w_rd] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  // Held instruction register and scoreboard state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid   <= 1'b0;
      r_op      <= '0;
      r_func    <= '0;
      r_rd      <= '0;
      r_wb      <= 1'b0;
      r_owner   <= 1'b0;
      r_imm     <= '0;
      r_pc      <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      if (flush)                   r_valid <= 1'b0;
      else if (w_xfer)             r_valid <= 1'b1;
      else if (r_valid && ex_ready) r_valid <= 1'b0;
      if (w_xfer) begin
        r_op    <= w_op;
        r_func  <= w_func;
        r_rd    <= w_rd;
        r_wb    <= w_wb;
        r_owner <= w_wb && !w_dst_busy;
        r_imm   <= w_imm;
        r_pc    <= if_pc;
        r_rs1   <= w_src1;
        r_rs2   <= w_src2;
      end
    end
  end

  assign ex_valid = r_valid;
  assign ex_op    = r_op;
  assign ex_func  = r_func;
  assign ex_rd    = r_rd;
  assign ex_wb    = r_wb;
  assign ex_imm   = r_imm;
  assign ex_pc    = r_pc;
  assign ex_a     = r_valid ? S1 : '0;
  assign ex_b     = r_valid ? S2 : '0;

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 clk  in  1  rising-edge clock; all state updates on it.
REQ-002 reset_n  in  1  asynchronous, active-low reset; one clock, no other reset.
REQ-003 if_valid/if_ready  in/out  1/1  fetch handshake; transfer when both high.
REQ-004 if_instr, if_pc  in  32, 32  DLX instruction word and its PC.
REQ-005 Rs1, Rs2  out  5, 5  register-file read addresses.
REQ-006 S1, S2  in  32, 32  register-file read data, valid one edge after Rs1/Rs2.
REQ-007 ex_valid/ex_ready  out/in  1/1  execute handshake; issue when both high.
REQ-008 ex_op 6, ex_func 11, ex_rd 5, ex_wb 1, ex_imm 32, ex_pc 32, ex_a 32, ex_b 32  out  held decoded instruction; ex_a/ex_b = S1/S2.
REQ-009 wb_valid, wb_rd  in  1, 5  writeback retiring a write to wb_rd.
REQ-010 flush  in  1  discard held instruction (taken branch).

Function
REQ-011 Fields: op=[31:26]; R-type (op=0): src1=[25:21], src2=[20:16], dst=[15:11], func=[10:0]; J/JAL (op 0x02/0x03): no sources, JAL dst=31; store (op 0x28-0x2B): src1=[25:21], src2=[20:16], no dst; BEQZ/BNEZ (0x04/0x05), JR/JALR (0x12/0x13): src1 only, JALR dst=31, otherwise no dst; all other I-type: src1=[25:21], dst=[20:16].
REQ-012 Immediate: I-type sign-extend [15:0]; ANDI/ORI/XORI (0x0C-0x0E) zero-extend; LHI (0x0F) {[15:0],16'h0}; J/JAL sign-extend [25:0]; R-type 0.
REQ-013 ex_wb=1 iff the instruction has a dst and dst!=0; ex_func=0 for non-R-type.
REQ-014 Scoreboard: 32-bit pending mask; bit 0 constantly 0.
REQ-015 Hazard when if_valid and a used source register has its pending bit set.
REQ-016 if_ready = !hazard && !flush && (!ex_valid || ex_ready).
REQ-017 Accept: the edge after transfer, held register loads decoded fields, ex_valid=1, pending[dst] set if ex_wb.
REQ-018 Rs1/Rs2 = source fields of if_instr when accepting, else those of the held instruction, so S1/S2 remain aligned with the held instruction during stalls; unused source fields still drive Rs1/Rs2.
REQ-019 Latency: accept at edge N -> ex_valid and ex_a/ex_b valid from edge N+1; throughput one per cycle.
REQ-020 Issue without new accept: ex_valid cleared; issue plus accept: new instruction replaces, no bubble.
REQ-021 wb_valid with wb_rd!=0 clears pending[wb_rd] at the edge; with a simultaneous set of the same bit, set wins.
REQ-022 Writeback in the same cycle as a hazard check still stalls that cycle (register file writes and reads at the same edge).
REQ-023 flush: ex_valid cleared next edge; pending bit set by the discarded unissued instruction cleared unless another writeback-pending instruction owns it (track an owner bit per held instruction); no accept that cycle.
REQ-024 ex_* fields hold stable while ex_valid && !ex_ready.

Reset
REQ-025 reset_n low: ex_valid=0, pending=0, all ex_* outputs 0, if_ready follows REQ-016 (1 when if_valid low), immediately and asynchronously.
REQ-026 reset mid-stall discards the held instruction; no pending state survives.

Verification
REQ-027 ADDI r3,r0,5 (0x20030005), ex_ready=1 -> next cycle ex_valid=1, ex_rd=3, ex_imm=5, ex_wb=1, pending[3]=1.
REQ-028 Then ADD r4,r3,r3 -> if_ready=0 until the cycle after wb_valid, wb_rd=3; accepted ex_a=ex_b=written value.
REQ-029 ORI r1,r0,0xFFFF -> ex_imm=0x0000FFFF; LHI r1,0x8000 -> ex_imm=0x80000000; ADDI imm 0xFFFF -> 0xFFFFFFFF.
REQ-030 ex_ready=0 for 3 cycles with if_valid=1 -> ex_* and Rs1/Rs2 stable, if_ready=0; release -> back-to-back issue.
REQ-031 flush with held ADDI r7 -> ex_valid=0, pending[7]=0; store and writes to r0 never set pending.
REQ-032 reset_n pulsed low while ex_valid=1, pending[3]=1 -> ex_valid=0, pending=0 without a clock edge.
